wb_mac_master: RTL and testbench

- Wishbone classic initiator that drives the MAC/DAC peripheral's register map on behalf of an on-chip requester.
- Accepts operand commands on a valid/ready port and performs the required single-beat writes and reads: write A, write B, accumulate-read, and on the last command the 48-bit P readout.
- Returns the accumulated result, or an error, on a valid/ready result port.
- Sits between a sequencer/CPU-side source and the peripheral's Wishbone slave port, clocked by the same Wishbone clock.

---
 rtl/wb_mac_master.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_mac_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mac_master.sv
// Wishbone classic initiator for the MAC/DAC peripheral. Each operand command
// becomes single-beat phases: write A, write B, accumulate-read and, on the last
// command, the two-word P readout. Every phase is followed by one idle bus cycle
// so that the peripheral's registered ACK can never re-trigger an accumulate.
module wb_mac_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [24:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data,
  output logic        res_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [31:0] OffA   = 32'h0;
  localparam logic [31:0] OffB   = 32'h4;
  localparam logic [31:0] OffPLo = 32'h8;
  localparam logic [31:0] OffPHi = 32'hC;
  localparam logic [31:0] OffAcc = 32'h10;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StWrA,
    StWrB,
    StAcc,
    StRdLo,
    StRdHi,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic [24:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        res_valid_q, res_valid_d;
  logic        res_err_q, res_err_d;
  logic [47:0] res_data_q, res_data_d;

  logic [31:0] ph_adr;
  logic        ph_we;
  logic [31:0] ph_dat;
  logic [7:0]  tcnt_inc;

  assign tcnt_inc = tcnt_q + 8'd1;

  // Bus fields for the phase owned by the current state (used after its gap).
  always_comb begin
    ph_adr = BASE_ADDR;
    ph_we  = 1'b0;
    ph_dat = 32'h0;
    unique case (state_q)
      StWrA: begin
        ph_adr = BASE_ADDR + OffA;
        ph_we  = 1'b1;
        ph_dat = {7'b0, a_q};
      end
      StWrB: begin
        ph_adr = BASE_ADDR + OffB;
        ph_we  = 1'b1;
        ph_dat = {16'b0, b_q};
      end
      StAcc:  ph_adr = BASE_ADDR + OffAcc;
      StRdLo: ph_adr = BASE_ADDR + OffPLo;
      StRdHi: ph_adr = BASE_ADDR + OffPHi;
      default: ;
    endcase
  end

  // Next-state logic: sequencing, bus handshake, timeout and result capture.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    last_d      = last_q;
    err_d       = err_q;
    p_lo_d      = p_lo_q;
    tcnt_d      = tcnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          last_d  = cmd_last;
          tcnt_d  = 8'd0;
          // Launch the A write straight from the command to save a cycle.
          state_d = StWrA;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = BASE_ADDR + OffA;
          dat_d   = {7'b0, cmd_a};
        end
      end

      StWrA, StWrB, StAcc, StRdLo, StRdHi: begin
        if (!stb_q) begin
          // Gap cycle just elapsed: start this state's phase.
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = ph_we;
          adr_d = ph_adr;
          dat_d = ph_dat;
        end else if (wbm_ack_i) begin
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          tcnt_d = 8'd0;
          unique case (state_q)
            StWrA: state_d = StWrB;
            StWrB: state_d = StAcc;
            StAcc: begin
              if (wbm_dat_i[24:0] != a_q) err_d = 1'b1;
              state_d = last_q ? StRdLo : StIdle;
            end
            StRdLo: begin
              p_lo_d  = wbm_dat_i;
              state_d = StRdHi;
            end
            default: begin
              // RD_HI: the result cycle doubles as the mandatory gap.
              state_d     = StResp;
              res_valid_d = 1'b1;
              res_err_d   = err_q;
              res_data_d  = err_q ? 48'h0 : {wbm_dat_i[15:0], p_lo_q};
            end
          endcase
        end else if (tcnt_inc == TimeoutCnt) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          tcnt_d      = 8'd0;
          state_d     = StResp;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_data_d  = 48'h0;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end

      StResp: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          res_data_d  = 48'h0;
          err_d       = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset drops the bus immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      a_q         <= 25'h0;
      b_q         <= 16'h0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      p_lo_q      <= 32'h0;
      tcnt_q      <= 8'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= 48'h0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      err_q       <= err_d;
      p_lo_q      <= p_lo_d;
      tcnt_q      <= tcnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == StIdle) && !res_valid_q;
  assign busy      = (state_q != StIdle);
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign res_data  = res_data_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = 1'b1;

endmodule

// File: tb/tb_wb_mac_master.sv
// Bench for wb_mac_master: a behavioural MAC peripheral answers the bus, and the
// expected P is an independent running sum of A*B mod 2^48.
module tb_wb_mac_master;

  localparam logic [31:0] Base = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [24:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_last = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res_data;
  logic        res_err;
  logic        busy;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  always #5 clk = ~clk;

  wb_mac_master #(
    .BASE_ADDR(Base),
    .TIMEOUT  (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_last  (cmd_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  // Peripheral model: registered ACK one cycle after STB, one ACK per strobe.
  logic        withhold_b = 1'b0;
  logic        acc_bad = 1'b0;
  logic        ack_inj = 1'b0;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic [24:0] s_a;
  logic [15:0] s_b;
  logic [47:0] s_p;
  logic [64:0] bus_log[$];
  int          stb_total = 0;

  assign wbm_ack_i = s_ack | ack_inj;
  assign wbm_dat_i = s_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack   <= 1'b0;
      s_rdata <= 32'h0;
      s_a     <= '0;
      s_b     <= '0;
      s_p     <= '0;
    end else begin
      s_ack <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !s_ack && !(withhold_b && wbm_adr_o == Base + 32'h4)) begin
        s_ack <= 1'b1;
        case (wbm_adr_o - Base)
          32'h0:  s_a <= wbm_dat_o[24:0];
          32'h4:  s_b <= wbm_dat_o[15:0];
          32'h10: begin
            s_rdata <= acc_bad ? {7'b0, s_a - 25'd1} : {7'b0, s_a};
            s_p     <= s_p + 48'(s_a) * 48'(s_b);
          end
          32'h8:  s_rdata <= s_p[31:0];
          32'hC:  s_rdata <= {16'h0, s_p[47:32]};
          default: s_rdata <= 32'hDEAD_BEEF;
        endcase
        bus_log.push_back({wbm_we_o, wbm_adr_o - Base, wbm_we_o ? wbm_dat_o : 32'h0});
      end
    end
  end

  always @(posedge clk) if (wbm_stb_o) stb_total <= stb_total + 1;

  int n_checks = 0;
  int n_err = 0;
  logic [47:0] exp_p = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [24:0] a, input logic [15:0] b, input logic last);
    int n;
    @(negedge clk);
    cmd_a = a;
    cmd_b = b;
    cmd_last = last;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accepted", 64'(n < 100), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 200);
  endtask

  task automatic wait_ready(output int lat, output logic saw_res);
    lat = 0;
    saw_res = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (res_valid) saw_res = 1'b1;
    end while (!cmd_ready && lat < 200);
  endtask

  task automatic consume;
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst_n = 1'b0;
    exp_p = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One last-command transaction, checked against the running model.
  task automatic run_last(input string tag, input logic [24:0] a, input logic [15:0] b);
    int lat;
    send(a, b, 1'b1);
    exp_p = exp_p + 48'(a) * 48'(b);
    wait_res(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd15);
    chk({tag, "_data"}, 64'(res_data), 64'(exp_p));
    chk({tag, "_err"}, 64'(res_err), 64'd0);
    consume();
  endtask

  initial begin
    int lat, l0, s0, n, acc_cnt;
    logic saw;
    logic hold_ok;
    logic [32:0] exp_ops[5];
    logic [64:0] e;

    exp_ops[0] = {1'b1, 32'h0};
    exp_ops[1] = {1'b1, 32'h4};
    exp_ops[2] = {1'b0, 32'h10};
    exp_ops[3] = {1'b0, 32'h8};
    exp_ops[4] = {1'b0, 32'hC};

    // Reset values while reset is held.
    #12;
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("rst_we", 64'(wbm_we_o), 64'd0);
    chk("rst_adr", 64'(wbm_adr_o), 64'd0);
    chk("rst_dat", 64'(wbm_dat_o), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("sel_const", 64'(wbm_sel_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsolicited ACK in idle must not move the FSM.
    @(negedge clk);
    ack_inj = 1'b1;
    @(negedge clk);
    ack_inj = 1'b0;
    @(negedge clk);
    chk("unsol_ack_busy", 64'(busy), 64'd0);
    chk("unsol_ack_stb", 64'(wbm_stb_o), 64'd0);

    // Basic 3*5 transaction with full bus trace.
    l0 = bus_log.size();
    s0 = stb_total;
    run_last("basic", 25'd3, 16'd5);
    chk("basic_log_len", 64'(bus_log.size() - l0), 64'd5);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      e = bus_log[l0 + i];
      chk($sformatf("basic_op%0d", i), 64'(e[64:32]), 64'(exp_ops[i]));
      if (e[64:32] == {1'b1, 32'h10}) acc_cnt++;
      if (e[64:32] == {1'b0, 32'h10}) acc_cnt++;
    end
    chk("basic_wr_a_dat", 64'(bus_log[l0][31:0]), 64'd3);
    chk("basic_wr_b_dat", 64'(bus_log[l0 + 1][31:0]), 64'd5);
    chk("basic_acc_strobes", 64'(acc_cnt), 64'd1);
    chk("basic_stb_cycles", 64'(stb_total - s0), 64'd10);
    chk("basic_res_cleared", 64'(res_valid), 64'd0);

    // Non-last command produces no result and frees the port after 9 cycles.
    reset_dut();
    send(25'd2, 16'd3, 1'b0);
    exp_p = exp_p + 48'd6;
    wait_ready(lat, saw);
    chk("nolast_ready_lat", 64'(lat), 64'd9);
    chk("nolast_no_result", 64'(saw), 64'd0);
    run_last("pair", 25'd4, 16'd5);

    // Full-scale operands, accumulating across three commands.
    reset_dut();
    for (int i = 0; i < 3; i++) run_last($sformatf("max%0d", i), 25'h1FF_FFFF, 16'hFFFF);

    // WR_B never acknowledged: abort after the timeout.
    withhold_b = 1'b1;
    l0 = bus_log.size();
    s0 = stb_total;
    send(25'd7, 16'd9, 1'b1);
    wait_res(lat);
    chk("tmo_latency", 64'(lat), 64'd20);
    chk("tmo_err", 64'(res_err), 64'd1);
    chk("tmo_data", 64'(res_data), 64'd0);
    chk("tmo_stb_cycles", 64'(stb_total - s0), 64'd18);
    chk("tmo_log_len", 64'(bus_log.size() - l0), 64'd1);
    consume();
    withhold_b = 1'b0;
    run_last("after_tmo", 25'd6, 16'd7);

    // ACC readback mismatch: P still read, result flagged.
    acc_bad = 1'b1;
    l0 = bus_log.size();
    send(25'h124, 16'd3, 1'b1);
    exp_p = exp_p + 48'h124 * 48'd3;
    wait_res(lat);
    chk("mis_err", 64'(res_err), 64'd1);
    chk("mis_data", 64'(res_data), 64'd0);
    chk("mis_log_len", 64'(bus_log.size() - l0), 64'd5);
    consume();
    acc_bad = 1'b0;
    run_last("after_mis", 25'd1, 16'd1);

    // Result held while res_ready stays low.
    send(25'd11, 16'd13, 1'b1);
    exp_p = exp_p + 48'd143;
    wait_res(lat);
    l0 = bus_log.size();
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== exp_p || res_err !== 1'b0 || cmd_ready || wbm_stb_o ||
          wbm_cyc_o) hold_ok = 1'b0;
    end
    chk("hold_stable", 64'(hold_ok), 64'd1);
    chk("hold_no_bus", 64'(bus_log.size() - l0), 64'd0);
    consume();

    // Randomised commands against the running-sum model.
    for (int i = 0; i < 24; i++) begin
      logic [24:0] ra;
      logic [15:0] rb;
      ra = 25'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        send(ra, rb, 1'b0);
        exp_p = exp_p + 48'(ra) * 48'(rb);
        wait_ready(lat, saw);
        chk($sformatf("rnd%0d_ready_lat", i), 64'(lat), 64'd9);
        chk($sformatf("rnd%0d_no_result", i), 64'(saw), 64'd0);
      end else begin
        run_last($sformatf("rnd%0d", i), ra, rb);
      end
    end

    // Reset during RD_LO: bus drops asynchronously, nothing is returned.
    send(25'd5, 16'd6, 1'b1);
    n = 0;
    while (!(wbm_stb_o && wbm_adr_o == Base + 32'h8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rdlo_reached", 64'(n < 100), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("arst_stb", 64'(wbm_stb_o), 64'd0);
    chk("arst_adr", 64'(wbm_adr_o), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    exp_p = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid || busy) saw = 1'b1;
    end
    chk("arst_no_result", 64'(saw), 64'd0);
    run_last("post_rst", 25'd2, 16'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
